// File: rtl/instr_fetch_buffer.sv
// Purpose  : fetch stage between a 1-cycle synchronous instruction ROM and decode; owns the fetch PC,
//            buffers returning words with their byte address, redirects and flushes on a jump load.
// Latency  : address issued in cycle N -> word on rom_rdata_i in N+1 -> instr_valid_o in N+2.
// Backpres.: head held stable while instr_valid_o & !instr_ready_i; issue stalls once the FIFO slots
//            plus the in-flight word reach FIFO_DEPTH.
//
// Ports:
//   clk_i, rstn_i          clock (rising edge), asynchronous active-low reset
//   jmp_addr_ld_i/_addr_i  redirect fetch to {jmp_addr_i[31:2],2'b00}; flushes queued and in-flight words
//   rom_addr_o/rom_rdata_i byte address to the ROM, word returned one cycle later
//   instr_o/instr_addr_o   instruction at FIFO head and its byte address
//   instr_valid_o/_ready_i valid/ready handshake towards decode

module instr_fetch_buffer #(
    parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        jmp_addr_ld_i,
    input  logic [31:0] jmp_addr_i,
    output logic [31:0] rom_addr_o,
    input  logic [31:0] rom_rdata_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_addr_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_V = (CW + 1)'(FIFO_DEPTH);

    // Fetch state
    logic [31:0] fetch_pc_q;
    logic        inflight_q;
    logic [31:0] inflight_addr_q;

    // Instruction FIFO
    logic [31:0]   fifo_instr_q [FIFO_DEPTH];
    logic [31:0]   fifo_addr_q  [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;

    logic          pop;
    logic          push;
    logic          issue;
    logic [CW:0]   credits_used;
    logic [31:0]   jmp_target;

    assign jmp_target    = {jmp_addr_i[31:2], 2'b00};
    assign instr_valid_o = (count_q != '0);
    assign pop           = instr_valid_o & instr_ready_i;

    // Outputs read zero whenever nothing is buffered, so a flushed or
    // freshly reset buffer never exposes an old word.
    assign instr_o      = instr_valid_o ? fifo_instr_q[rd_ptr_q] : 32'h0;
    assign instr_addr_o = instr_valid_o ? fifo_addr_q[rd_ptr_q]  : 32'h0;

    // Redirect target goes straight to the ROM in the jump cycle so the
    // new stream starts without an extra bubble.
    assign rom_addr_o = jmp_addr_ld_i ? jmp_target : fetch_pc_q;

    // Slots committed for the next cycle: what stays in the FIFO after this
    // cycle's pop plus the word already on its way back from the ROM.
    // pop implies count_q > 0, so the subtraction never underflows.
    always_comb begin
        credits_used = {1'b0, count_q}
                     - {{CW{1'b0}}, pop}
                     + {{CW{1'b0}}, inflight_q};
    end

    // A jump empties everything, so the full depth is available to the target.
    assign issue = jmp_addr_ld_i | (credits_used < DEPTH_V);

    // The ROM word of an in-flight request belongs to the old stream when a
    // jump is loaded in the same cycle, so it is dropped.
    assign push = inflight_q & ~jmp_addr_ld_i;

    // Fetch PC and in-flight tracking
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            fetch_pc_q      <= BOOT_ADDR;
            inflight_q      <= 1'b0;
            inflight_addr_q <= 32'h0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                inflight_addr_q <= rom_addr_o;
                fetch_pc_q      <= rom_addr_o + 32'd4;
            end else if (jmp_addr_ld_i) begin
                fetch_pc_q      <= jmp_target;
            end
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (jmp_addr_ld_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage; a push into a full FIFO only happens together with a
    // pop, in which case wr_ptr_q equals rd_ptr_q and the head is replaced
    // exactly as it leaves.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_instr_q[i] <= 32'h0;
                fifo_addr_q[i]  <= 32'h0;
            end
        end else if (push) begin
            fifo_instr_q[wr_ptr_q] <= rom_rdata_i;
            fifo_addr_q[wr_ptr_q]  <= inflight_addr_q;
        end
    end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
module tb_instr_fetch_buffer;

    localparam logic [31:0] BOOT  = 32'h0000_0000;
    localparam int          DEPTH = 2;

    logic        clk_i;
    logic        rstn_i;
    logic        jmp_addr_ld_i;
    logic [31:0] jmp_addr_i;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_rdata_i;
    logic [31:0] instr_o;
    logic [31:0] instr_addr_o;
    logic        instr_valid_o;
    logic        instr_ready_i;

    int n_vec;
    int n_err;

    instr_fetch_buffer #(
        .BOOT_ADDR (BOOT),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .jmp_addr_ld_i(jmp_addr_ld_i),
        .jmp_addr_i   (jmp_addr_i),
        .rom_addr_o   (rom_addr_o),
        .rom_rdata_i  (rom_rdata_i),
        .instr_o      (instr_o),
        .instr_addr_o (instr_addr_o),
        .instr_valid_o(instr_valid_o),
        .instr_ready_i(instr_ready_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // 1K-word ROM image, aliasing modulo its size
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'hA5A5_0000 | {22'b0, a[11:2]};
    endfunction

    // Synchronous ROM, one cycle read latency, no enable
    always @(posedge clk_i) rom_rdata_i <= rom_word(rom_addr_o);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: buffered word addresses, the request awaiting its ROM
    // word, the next fetch address, and the next address decode should see.
    logic [31:0] mq[$];
    logic        m_pend;
    logic [31:0] m_pend_addr;
    logic [31:0] m_pc;
    logic [31:0] m_next;

    function automatic void model_reset();
        mq.delete();
        m_pend      = 1'b0;
        m_pend_addr = 32'h0;
        m_pc        = BOOT;
        m_next      = BOOT;
    endfunction

    // One clock cycle: drive inputs just after the rising edge, compare at the
    // falling edge, then advance the model by the edge that closes the cycle.
    task automatic step(input logic jmp, input logic [31:0] tgt, input logic rdy);
        logic        exp_vld;
        logic        pop;
        logic        issue;
        logic [31:0] iss_addr;
        int          used;
        jmp_addr_ld_i = jmp;
        jmp_addr_i    = tgt;
        instr_ready_i = rdy;
        @(negedge clk_i);
        exp_vld  = (mq.size() != 0);
        iss_addr = jmp ? {tgt[31:2], 2'b00} : m_pc;
        chk("instr_valid", {31'b0, instr_valid_o}, {31'b0, exp_vld});
        chk("rom_addr", rom_addr_o, iss_addr);
        if (exp_vld) begin
            chk("instr_addr", instr_addr_o, mq[0]);
            chk("instr_data", instr_o, rom_word(mq[0]));
        end
        pop = exp_vld && rdy;
        if (pop) begin
            chk("stream_order", instr_addr_o, m_next);
            m_next = m_next + 32'd4;
        end
        used  = mq.size() - (pop ? 1 : 0) + (m_pend ? 1 : 0);
        issue = jmp || (used < DEPTH);
        if (jmp) begin
            mq.delete();
            m_next = iss_addr;
        end else begin
            if (pop) void'(mq.pop_front());
            if (m_pend) mq.push_back(m_pend_addr);
        end
        m_pend = issue;
        if (issue) begin
            m_pend_addr = iss_addr;
            m_pc        = iss_addr + 32'd4;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, {31'b0, instr_valid_o}, 32'h0);
        chk({tag, "_instr"}, instr_o, 32'h0);
        chk({tag, "_iaddr"}, instr_addr_o, 32'h0);
        chk({tag, "_rom_addr"}, rom_addr_o, BOOT);
    endtask

    // Reset asserted off-edge for one cycle; outputs must clear at once.
    task automatic reset_pulse();
        jmp_addr_ld_i = 1'b0;
        rstn_i        = 1'b0;
        #1;
        check_reset_outputs("rst_pulse");
        model_reset();
        @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
    endtask

    initial begin
        n_vec         = 0;
        n_err         = 0;
        rstn_i        = 1'b0;
        jmp_addr_ld_i = 1'b0;
        jmp_addr_i    = 32'h0;
        instr_ready_i = 1'b0;
        model_reset();
        repeat (3) @(posedge clk_i);
        #1;
        check_reset_outputs("reset");
        rstn_i = 1'b1;

        // Boot stream with decode always ready
        repeat (8) step(1'b0, 32'h0, 1'b1);

        // Backpressure mid-stream, then release
        repeat (6) step(1'b0, 32'h0, 1'b0);
        repeat (6) step(1'b0, 32'h0, 1'b1);

        // Misaligned jump target
        step(1'b1, 32'h0000_0043, 1'b1);
        repeat (6) step(1'b0, 32'h0, 1'b1);

        // Back-to-back jumps, last one wins
        step(1'b1, 32'h0000_0100, 1'b1);
        step(1'b1, 32'h0000_0200, 1'b1);
        repeat (6) step(1'b0, 32'h0, 1'b1);

        // Fetch PC wrap at the top of the address space
        step(1'b1, 32'hFFFF_FFF8, 1'b1);
        repeat (6) step(1'b0, 32'h0, 1'b1);

        // Jump while full and stalled
        repeat (5) step(1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h0000_0300, 1'b0);
        repeat (3) step(1'b0, 32'h0, 1'b0);
        repeat (5) step(1'b0, 32'h0, 1'b1);

        // Reset mid-stream, restart from boot address
        reset_pulse();
        repeat (8) step(1'b0, 32'h0, 1'b1);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            logic        j;
            logic [31:0] t;
            logic        r;
            if ($urandom_range(0, 599) == 0) begin
                reset_pulse();
            end
            j = ($urandom_range(0, 19) == 0);
            t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            r = ($urandom_range(0, 3) != 0);
            step(j, t, r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
